wb_dual_arbiter: RTL and testbench

WB_DUAL_ARBITER -- requirements
Module: wb_dual_arbiter

---
 rtl/wb_dual_arbiter.sv | 159 +++++++++++++++
 tb/tb_wb_dual_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wb_dual_arbiter.sv
// Two-master Wishbone arbiter onto one slave: round-robin on contention, grant held for the whole cycle.
// Optional bus watchdog compiled in with `define WB_ARB_TIMEOUT_EN.
module wb_dual_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m0_cyc_i,
   input  logic                m0_stb_i,
   input  logic                m0_we_i,
   input  logic [ADDR_W-1:0]   m0_adr_i,
   input  logic [DATA_W-1:0]   m0_dat_i,
   input  logic [DATA_W/8-1:0] m0_sel_i,
   input  logic [2:0]          m0_cti_i,
   input  logic [1:0]          m0_bte_i,
   output logic                m0_ack_o,
   output logic                m0_err_o,
   output logic                m0_rty_o,
   output logic [DATA_W-1:0]   m0_dat_o,
   input  logic                m1_cyc_i,
   input  logic                m1_stb_i,
   input  logic                m1_we_i,
   input  logic [ADDR_W-1:0]   m1_adr_i,
   input  logic [DATA_W-1:0]   m1_dat_i,
   input  logic [DATA_W/8-1:0] m1_sel_i,
   input  logic [2:0]          m1_cti_i,
   input  logic [1:0]          m1_bte_i,
   output logic                m1_ack_o,
   output logic                m1_err_o,
   output logic                m1_rty_o,
   output logic [DATA_W-1:0]   m1_dat_o,
   output logic                s_cyc_o,
   output logic                s_stb_o,
   output logic                s_we_o,
   output logic [ADDR_W-1:0]   s_adr_o,
   output logic [DATA_W-1:0]   s_dat_o,
   output logic [DATA_W/8-1:0] s_sel_o,
   output logic [2:0]          s_cti_o,
   output logic [1:0]          s_bte_o,
   input  logic                s_ack_i,
   input  logic                s_err_i,
   input  logic                s_rty_i,
   input  logic [DATA_W-1:0]   s_dat_i,
   output logic [1:0]          gnt_o,
   output logic                timeout_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, GRANT0 = 2'd1, GRANT1 = 2'd2} state_t;

   state_t r_state;
   state_t w_next;
   logic   r_last;   // 1: m1 held the most recent grant
   logic   w_to;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] r_cnt;
   logic             w_resp;

   assign w_resp    = s_ack_i | s_err_i | s_rty_i;
   assign w_to      = (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT));
   assign timeout_o = w_to;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (r_state == IDLE || w_resp) begin
         r_cnt <= '0;
      end else if (s_stb_o) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end
`else
   // No watchdog: expiry can never fire, the grant lasts until cyc drops.
   assign w_to      = (TIMEOUT < 0);
   assign timeout_o = w_to;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next == GRANT0) r_last <= 1'b0;
         if (r_state == IDLE && w_next == GRANT1) r_last <= 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (m0_cyc_i && m1_cyc_i) w_next = r_last ? GRANT0 : GRANT1;
            else if (m0_cyc_i)        w_next = GRANT0;
            else if (m1_cyc_i)        w_next = GRANT1;
         end
         GRANT0:  if (!m0_cyc_i || w_to) w_next = IDLE;
         GRANT1:  if (!m1_cyc_i || w_to) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_cti_o  = '0;
      s_bte_o  = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m0_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      m1_dat_o = '0;
      gnt_o    = 2'b00;
      case (r_state)
         GRANT0: begin
            gnt_o    = 2'b01;
            s_cyc_o  = m0_cyc_i & ~w_to;
            s_stb_o  = m0_stb_i & ~w_to;
            s_we_o   = m0_we_i;
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_sel_o  = m0_sel_i;
            s_cti_o  = m0_cti_i;
            s_bte_o  = m0_bte_i;
            m0_ack_o = s_ack_i & ~w_to;
            m0_err_o = s_err_i | w_to;
            m0_rty_o = s_rty_i & ~w_to;
            m0_dat_o = s_dat_i;
         end
         GRANT1: begin
            gnt_o    = 2'b10;
            s_cyc_o  = m1_cyc_i & ~w_to;
            s_stb_o  = m1_stb_i & ~w_to;
            s_we_o   = m1_we_i;
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_cti_o  = m1_cti_i;
            s_bte_o  = m1_bte_i;
            m1_ack_o = s_ack_i & ~w_to;
            m1_err_o = s_err_i | w_to;
            m1_rty_o = s_rty_i & ~w_to;
            m1_dat_o = s_dat_i;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_dual_arbiter.sv
// Directed bench for wb_dual_arbiter: grant latency, round-robin, bursts, watchdog, reset abort.
module tb_wb_dual_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_cyc_i, m0_stb_i, m0_we_i;
   logic [31:0] m0_adr_i, m0_dat_i;
   logic [3:0]  m0_sel_i;
   logic [2:0]  m0_cti_i;
   logic [1:0]  m0_bte_i;
   logic        m0_ack_o, m0_err_o, m0_rty_o;
   logic [31:0] m0_dat_o;
   logic        m1_cyc_i, m1_stb_i, m1_we_i;
   logic [31:0] m1_adr_i, m1_dat_i;
   logic [3:0]  m1_sel_i;
   logic [2:0]  m1_cti_i;
   logic [1:0]  m1_bte_i;
   logic        m1_ack_o, m1_err_o, m1_rty_o;
   logic [31:0] m1_dat_o;
   logic        s_cyc_o, s_stb_o, s_we_o;
   logic [31:0] s_adr_o, s_dat_o;
   logic [3:0]  s_sel_o;
   logic [2:0]  s_cti_o;
   logic [1:0]  s_bte_o;
   logic        s_ack_i, s_err_i, s_rty_i;
   logic [31:0] s_dat_i;
   logic [1:0]  gnt_o;
   logic        timeout_o;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_dual_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
      .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
      .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o), .m0_dat_o(m0_dat_o),
      .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
      .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
      .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o), .m1_dat_o(m1_dat_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
      .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
      .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_dat_i(s_dat_i),
      .gnt_o(gnt_o), .timeout_o(timeout_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      {m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i} = '0;
      m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF; m0_cti_i = '0; m0_bte_i = '0;
      m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = 4'hF; m1_cti_i = '0; m1_bte_i = '0;
      {s_ack_i, s_err_i, s_rty_i} = '0;
      s_dat_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_scyc", 32'(s_cyc_o), 32'h0);
      check("rst_timeout", 32'(timeout_o), 32'h0);
      rst = 1'b1;

      // m0 single read; ack arrives in the same cycle m0 drops cyc
      @(posedge clk); #1;
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h100;
      @(negedge clk);
      check("lat_scyc_idle", 32'(s_cyc_o), 32'h0);
      @(negedge clk);
      check("rd_scyc", 32'(s_cyc_o), 32'h1);
      check("rd_gnt", 32'(gnt_o), 32'h1);
      check("rd_adr", s_adr_o, 32'h100);
      s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1;
      check("rd_m0_ack", 32'(m0_ack_o), 32'h1);
      check("rd_m0_dat", m0_dat_o, 32'hDEADBEEF);
      check("rd_m1_ack", 32'(m1_ack_o), 32'h0);
      check("rd_m1_dat", m1_dat_o, 32'h0);
      @(posedge clk); #1;
      s_ack_i = 1'b0; s_dat_i = '0;
      @(negedge clk);
      check("rd_idle_gnt", 32'(gnt_o), 32'h0);
      check("rd_idle_scyc", 32'(s_cyc_o), 32'h0);

      // contention after reset: m0 wins, then m1 after one idle cycle, then m0 again
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h200;
      @(negedge clk);
      @(negedge clk);
      check("rr1_gnt", 32'(gnt_o), 32'h1);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      @(negedge clk);
      check("rr_idle_gnt", 32'(gnt_o), 32'h0);
      @(negedge clk);
      check("rr2_gnt", 32'(gnt_o), 32'h2);
      check("rr2_adr", s_adr_o, 32'h200);
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      @(negedge clk);
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      @(negedge clk);
      check("rr3_gnt", 32'(gnt_o), 32'h1);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      @(negedge clk);
      check("rr3_idle", 32'(gnt_o), 32'h0);

      // m1 4-beat incrementing burst with m0 waiting (m1 wins: m0 was last)
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cti_i = 3'b010;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("bst_gnt", 32'(gnt_o), 32'h2);
         if (i == 0) check("bst_cti", 32'(s_cti_o), 32'h2);
         s_ack_i = 1'b1; s_dat_i = 32'hA0 + 32'(i);
         if (i == 3) m1_cti_i = 3'b111;
         #1;
         check("bst_m1_ack", 32'(m1_ack_o), 32'h1);
         check("bst_m1_dat", m1_dat_o, 32'hA0 + 32'(i));
         check("bst_m0_ack", 32'(m0_ack_o), 32'h0);
         if (i == 3) begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
         @(posedge clk); #1;
         s_ack_i = 1'b0; s_dat_i = '0;
      end
      @(negedge clk);
      check("bst_idle_gnt", 32'(gnt_o), 32'h0);
      @(negedge clk);
      check("bst_m0_gnt", 32'(gnt_o), 32'h1);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      @(negedge clk);

      // m0 write that the slave never acknowledges
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1; m0_dat_i = 32'h55;
      @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("wd_stall_scyc", 32'(s_cyc_o), 32'h1);
         check("wd_stall_to", 32'(timeout_o), 32'h0);
         @(posedge clk);
      end
      @(negedge clk);
`ifdef WB_ARB_TIMEOUT_EN
      check("wd_err", 32'(m0_err_o), 32'h1);
      check("wd_to", 32'(timeout_o), 32'h1);
      check("wd_scyc", 32'(s_cyc_o), 32'h0);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
      @(negedge clk);
      check("wd_idle_gnt", 32'(gnt_o), 32'h0);
      check("wd_to_pulse", 32'(timeout_o), 32'h0);
      check("wd_err_pulse", 32'(m0_err_o), 32'h0);
`else
      check("nowd_err", 32'(m0_err_o), 32'h0);
      check("nowd_to", 32'(timeout_o), 32'h0);
      check("nowd_scyc", 32'(s_cyc_o), 32'h1);
      check("nowd_gnt", 32'(gnt_o), 32'h1);
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
      @(negedge clk);
      check("nowd_idle_gnt", 32'(gnt_o), 32'h0);
`endif

      // reset during m1 burst beat 2 aborts the transfer
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010;
      @(negedge clk);
      check("rab_gnt", 32'(gnt_o), 32'h2);
      s_ack_i = 1'b1;
      @(posedge clk); #1;
      s_ack_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; s_ack_i = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      @(negedge clk);
      check("rab_scyc", 32'(s_cyc_o), 32'h0);
      check("rab_sstb", 32'(s_stb_o), 32'h0);
      check("rab_gnt0", 32'(gnt_o), 32'h0);
      check("rab_m1_ack", 32'(m1_ack_o), 32'h0);
      s_ack_i = 1'b0;
      @(negedge clk);
      check("rab_m0_gnt", 32'(gnt_o), 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
